// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 round controller: state encoding,
// block geometry, the initial hash value H0 and the round constants K.
package sha256_pkg;

  localparam int MSG_WORDS  = 16;
  localparam int MAX_ROUNDS = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    LOAD   = 3'd2,
    EXPAND = 3'd3,
    UPDATE = 3'd4
  } ctrl_state_t;

  localparam logic [31:0] H0 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

endpackage

// File: rtl/sha256_k_rom.sv
// SHA-256 round-constant ROM: round index -> K[t]. Purely combinational so the
// constant is available in the same cycle as the round it belongs to.
module sha256_k_rom
  import sha256_pkg::*;
(
  input  logic [5:0]  round_idx,
  output logic [31:0] k_word
);

  // NOTE: assign a default before the case so no path leaves k_word unassigned
  // and infers a latch, even if the case is edited to be incomplete later.
  always_comb begin
    k_word = '0;
    case (round_idx)
      6'd0:  k_word = 32'h428a2f98;  6'd1:  k_word = 32'h71374491;  6'd2:  k_word = 32'hb5c0fbcf;  6'd3:  k_word = 32'he9b5dba5;
      6'd4:  k_word = 32'h3956c25b;  6'd5:  k_word = 32'h59f111f1;  6'd6:  k_word = 32'h923f82a4;  6'd7:  k_word = 32'hab1c5ed5;
      6'd8:  k_word = 32'hd807aa98;  6'd9:  k_word = 32'h12835b01;  6'd10: k_word = 32'h243185be;  6'd11: k_word = 32'h550c7dc3;
      6'd12: k_word = 32'h72be5d74;  6'd13: k_word = 32'h80deb1fe;  6'd14: k_word = 32'h9bdc06a7;  6'd15: k_word = 32'hc19bf174;
      6'd16: k_word = 32'he49b69c1;  6'd17: k_word = 32'hefbe4786;  6'd18: k_word = 32'h0fc19dc6;  6'd19: k_word = 32'h240ca1cc;
      6'd20: k_word = 32'h2de92c6f;  6'd21: k_word = 32'h4a7484aa;  6'd22: k_word = 32'h5cb0a9dc;  6'd23: k_word = 32'h76f988da;
      6'd24: k_word = 32'h983e5152;  6'd25: k_word = 32'ha831c66d;  6'd26: k_word = 32'hb00327c8;  6'd27: k_word = 32'hbf597fc7;
      6'd28: k_word = 32'hc6e00bf3;  6'd29: k_word = 32'hd5a79147;  6'd30: k_word = 32'h06ca6351;  6'd31: k_word = 32'h14292967;
      6'd32: k_word = 32'h27b70a85;  6'd33: k_word = 32'h2e1b2138;  6'd34: k_word = 32'h4d2c6dfc;  6'd35: k_word = 32'h53380d13;
      6'd36: k_word = 32'h650a7354;  6'd37: k_word = 32'h766a0abb;  6'd38: k_word = 32'h81c2c92e;  6'd39: k_word = 32'h92722c85;
      6'd40: k_word = 32'ha2bfe8a1;  6'd41: k_word = 32'ha81a664b;  6'd42: k_word = 32'hc24b8b70;  6'd43: k_word = 32'hc76c51a3;
      6'd44: k_word = 32'hd192e819;  6'd45: k_word = 32'hd6990624;  6'd46: k_word = 32'hf40e3585;  6'd47: k_word = 32'h106aa070;
      6'd48: k_word = 32'h19a4c116;  6'd49: k_word = 32'h1e376c08;  6'd50: k_word = 32'h2748774c;  6'd51: k_word = 32'h34b0bcb5;
      6'd52: k_word = 32'h391c0cb3;  6'd53: k_word = 32'h4ed8aa4a;  6'd54: k_word = 32'h5b9cca4f;  6'd55: k_word = 32'h682e6ff3;
      6'd56: k_word = 32'h748f82ee;  6'd57: k_word = 32'h78a5636f;  6'd58: k_word = 32'h84c87814;  6'd59: k_word = 32'h8cc70208;
      6'd60: k_word = 32'h90befffa;  6'd61: k_word = 32'ha4506ceb;  6'd62: k_word = 32'hbef9a3f7;  6'd63: k_word = 32'hc67178f2;
      default: k_word = '0;
    endcase
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Block sequencer for the SHA-256 compression datapath (IDLE/INIT/LOAD/EXPAND/UPDATE).
// Optional SHA256_CTRL_CHAIN_EN adds the chain input so multi-block messages continue from H.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = MAX_ROUNDS  // legal 17..64; below 64 only for reduced-round builds
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef SHA256_CTRL_CHAIN_EN
  input  logic        chain,
`endif
  input  logic        msg_valid,
  output logic        msg_ready,
  output logic        state_init,
  output logic        init_iv,
  output logic        w_load,
  output logic        w_expand,
  output logic [5:0]  round_idx,
  output logic [31:0] k_word,
  output logic        hash_update,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST_MSG   = 6'(MSG_WORDS - 1);
  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  ctrl_state_t state_q, state_d;
  logic [5:0]  round_idx_q, round_idx_d;
  logic        done_q, done_d;

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = INIT;
      INIT: begin
        round_idx_d = '0;
        state_d     = LOAD;
      end
      LOAD: begin
        // A stalled word source freezes both the round counter and the state.
        if (msg_valid) begin
          round_idx_d = round_idx_q + 6'd1;
          if (round_idx_q == LAST_MSG) state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (round_idx_q == LAST_ROUND) state_d = UPDATE;
        else                           round_idx_d = round_idx_q + 6'd1;
      end
      UPDATE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_idx_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      done_q      <= done_d;
    end
  end

`ifdef SHA256_CTRL_CHAIN_EN
  logic chain_q, chain_d;

  always_comb begin
    chain_d = chain_q;
    if (state_q == IDLE && start) chain_d = chain;
  end

  always_ff @(posedge clk) begin
    if (rst) chain_q <= 1'b0;
    else     chain_q <= chain_d;
  end

  assign init_iv = (state_q == INIT) & ~chain_q;
`else
  assign init_iv = (state_q == INIT);
`endif

  assign msg_ready   = (state_q == LOAD);
  assign state_init  = (state_q == INIT);
  assign w_load      = (state_q == LOAD) & msg_valid;
  assign w_expand    = (state_q == EXPAND);
  assign hash_update = (state_q == UPDATE);
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign round_idx   = round_idx_q;

  sha256_k_rom u_k_rom (
    .round_idx (round_idx_q),
    .k_word    (k_word)
  );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl with a behavioural SHA-256 datapath attached.
// Build with SHA256_CTRL_CHAIN_EN defined to also exercise two-block chaining.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  localparam int ROUNDS = 64;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] TWO_DIG =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic        clk = 1'b0;
  logic        rst, start, msg_valid;
  logic        chain;
  logic        msg_ready, state_init, init_iv, w_load, w_expand, hash_update, busy, done;
  logic [5:0]  round_idx;
  logic [31:0] k_word;

  always #5 clk = ~clk;

  sha256_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
`ifdef SHA256_CTRL_CHAIN_EN
    .chain       (chain),
`endif
    .msg_valid   (msg_valid),
    .msg_ready   (msg_ready),
    .state_init  (state_init),
    .init_iv     (init_iv),
    .w_load      (w_load),
    .w_expand    (w_expand),
    .round_idx   (round_idx),
    .k_word      (k_word),
    .hash_update (hash_update),
    .busy        (busy),
    .done        (done)
  );

  logic [5:0]  rom_addr;
  logic [31:0] rom_k;
  sha256_k_rom u_rom (.round_idx(rom_addr), .k_word(rom_k));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural datapath ----------------
  typedef logic [31:0] word_t;
  typedef logic [7:0][31:0] wv_t;

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic word_t bsig0(word_t x); return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22); endfunction
  function automatic word_t bsig1(word_t x); return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25); endfunction
  function automatic word_t ssig0(word_t x); return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);   endfunction
  function automatic word_t ssig1(word_t x); return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10); endfunction

  function automatic wv_t do_round(wv_t s, word_t k, word_t w);
    wv_t   r;
    word_t t1, t2;
    t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[7] = s[6]; r[6] = s[5]; r[5] = s[4]; r[4] = s[3] + t1;
    r[3] = s[2]; r[2] = s[1]; r[1] = s[0]; r[0] = t1 + t2;
    return r;
  endfunction

  function automatic wv_t iv_vec();
    wv_t v;
    for (int i = 0; i < 8; i++) v[i] = H0[i];
    return v;
  endfunction

  function automatic wv_t add_vec(wv_t a, wv_t b);
    wv_t r;
    for (int i = 0; i < 8; i++) r[i] = a[i] + b[i];
    return r;
  endfunction

  function automatic logic [255:0] digest_of(wv_t h);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[255 - 32*i -: 32] = h[i];
    return d;
  endfunction

  word_t cur_msg [16];
  word_t wsch    [64];
  wv_t   wk, hh;

  function automatic word_t expand_w(logic [5:0] t);
    if (t < 6'd16) return '0;
    return ssig1(wsch[t-2]) + wsch[t-7] + ssig0(wsch[t-15]) + wsch[t-16];
  endfunction

  always @(posedge clk) begin
    if (state_init) begin
      if (init_iv) begin
        hh <= iv_vec();
        wk <= iv_vec();
      end else begin
        wk <= hh;
      end
    end
    if (w_load) begin
      wsch[round_idx] <= cur_msg[round_idx[3:0]];
      wk <= do_round(wk, k_word, cur_msg[round_idx[3:0]]);
    end
    if (w_expand) begin
      wsch[round_idx] <= expand_w(round_idx);
      wk <= do_round(wk, k_word, expand_w(round_idx));
    end
    if (hash_update) hh <= add_vec(hh, wk);
  end

  // ---------------- word source with programmable stall ----------------
  int stall_at  = -1;
  int stall_len = 0;
  int stall_cnt = 0;

  initial begin
    msg_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (state_init) stall_cnt = 0;
      if (msg_ready && int'(round_idx) == stall_at && stall_cnt < stall_len) begin
        msg_valid = 1'b0;
        stall_cnt++;
      end else if (msg_ready) begin
        msg_valid = 1'b1;
      end else begin
        msg_valid = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    int           lat;
    int           loads;
    int           exps;
    int           upds;
    bit           chk_dig;
    logic [255:0] dig;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   in_flight = 1'b0;
  int   start_cyc, n_load, n_exp, n_upd, exp_idx;
  logic exp_iv = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        in_flight = 1'b0;
      end else begin
        check("strobe_onehot", 256'($countones({state_init, w_load, w_expand, hash_update}) <= 1), 1);
        check("w_load_qual", w_load, msg_ready & msg_valid);
        if (state_init) begin
          check("init_iv", init_iv, exp_iv);
          exp_idx = 0;
        end
        if (msg_ready || w_expand) check("round_idx", round_idx, exp_idx);
        if (w_load || w_expand) begin
          check("k_word", k_word, K[round_idx]);
          exp_idx++;
        end
        if (w_load)      n_load++;
        if (w_expand)    n_exp++;
        if (hash_update) n_upd++;
        if (done) begin
          check("done_pending", (sb.size() != 0) && in_flight, 1);
          if (sb.size() != 0 && in_flight) begin
            mon_e = sb.pop_front();
            check("latency", cyc - start_cyc, mon_e.lat);
            check("n_w_load", n_load, mon_e.loads);
            check("n_w_expand", n_exp, mon_e.exps);
            check("n_hash_update", n_upd, mon_e.upds);
            if (mon_e.chk_dig) check("digest", digest_of(hh), mon_e.dig);
          end
          in_flight = 1'b0;
        end
        if (start && !busy) begin
          in_flight = 1'b1;
          start_cyc = cyc;
          n_load = 0; n_exp = 0; n_upd = 0;
`ifdef SHA256_CTRL_CHAIN_EN
          exp_iv = ~chain;
`else
          exp_iv = 1'b1;
`endif
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct { int stall_at; int stall_len; int lat; } blk_vec_t;
  typedef struct { logic [5:0] addr; logic [31:0] k; } rom_vec_t;

  task automatic set_abc();
    cur_msg = '{default: 32'h0};
    cur_msg[0]  = 32'h61626380;
    cur_msg[15] = 32'h00000018;
  endtask

  function automatic exp_t mk_exp(int lat, bit chk, logic [255:0] dig);
    exp_t e;
    e.lat = lat; e.loads = MSG_WORDS; e.exps = ROUNDS - MSG_WORDS; e.upds = 1;
    e.chk_dig = chk; e.dig = dig;
    return e;
  endfunction

  task automatic start_block(input bit push, input exp_t e);
    @(posedge clk); #1;
    start = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (sb.size() != 0 || busy); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  blk_vec_t vecs [4];
  rom_vec_t roms [8];
  int       t_upd, t_init;

  initial begin
    rst = 1'b1; start = 1'b0; chain = 1'b0; rom_addr = '0;
    set_abc();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {msg_ready, state_init, init_iv, w_load, w_expand, hash_update, busy, done}, 8'h00);
    check("reset_round_idx", round_idx, 0);

    roms[0] = '{6'd0,  32'h428a2f98}; roms[1] = '{6'd1,  32'h71374491};
    roms[2] = '{6'd15, 32'hc19bf174}; roms[3] = '{6'd16, 32'he49b69c1};
    roms[4] = '{6'd31, 32'h14292967}; roms[5] = '{6'd32, 32'h27b70a85};
    roms[6] = '{6'd62, 32'hbef9a3f7}; roms[7] = '{6'd63, 32'hc67178f2};
    for (int i = 0; i < 8; i++) begin
      rom_addr = roms[i].addr;
      #1;
      check("k_rom", rom_k, roms[i].k);
    end

    // zero-stall, stall after word 5, stall on first word, stall on last word
    vecs[0] = '{-1, 0, 67};
    vecs[1] = '{ 6, 3, 70};
    vecs[2] = '{ 0, 1, 68};
    vecs[3] = '{15, 2, 69};
    for (int i = 0; i < 4; i++) begin
      stall_at  = vecs[i].stall_at;
      stall_len = vecs[i].stall_len;
      start_block(1'b1, mk_exp(vecs[i].lat, 1'b1, ABC_DIG));
      drain("drain_vec");
    end
    stall_at = -1; stall_len = 0;

    // start pulsed in cycle 20 of a running block is ignored
    start_block(1'b1, mk_exp(67, 1'b1, ABC_DIG));
    repeat (19) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_ignored", {state_init, busy}, 2'b01);
    drain("drain_ignored");
    repeat (80) @(negedge clk);

    // reset during EXPAND at round 30 abandons the block
    start_block(1'b0, mk_exp(0, 1'b0, '0));
    for (int i = 0; i < 200 && !(w_expand && round_idx == 6'd30); i++) @(negedge clk);
    check("reached_round30", {w_expand, round_idx}, {1'b1, 6'd30});
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_outputs", {busy, done, w_expand, hash_update}, 4'h0);
    check("midrst_round_idx", round_idx, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (90) @(negedge clk);
    check("midrst_no_done_pending", sb.size(), 0);

    // back-to-back with start held high
    @(posedge clk); #1;
    start = 1'b1;
    sb.push_back(mk_exp(67, 1'b1, ABC_DIG));
    sb.push_back(mk_exp(67, 1'b1, ABC_DIG));
    @(negedge clk);
    for (int i = 0; i < 200 && !hash_update; i++) @(negedge clk);
    t_upd = cyc;
    @(negedge clk);
    for (int i = 0; i < 10 && !state_init; i++) @(negedge clk);
    t_init = cyc;
    check("b2b_gap", t_init - t_upd, 2);
    @(posedge clk); #1;
    start = 1'b0;
    drain("drain_b2b");

`ifdef SHA256_CTRL_CHAIN_EN
    // two-block 56-byte message, second block chained from H
    cur_msg = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    chain = 1'b0;
    start_block(1'b1, mk_exp(67, 1'b0, '0));
    drain("drain_chain1");
    cur_msg = '{default: 32'h0};
    cur_msg[15] = 32'h000001c0;
    chain = 1'b1;
    start_block(1'b1, mk_exp(67, 1'b1, TWO_DIG));
    for (int i = 0; i < 10 && !state_init; i++) @(negedge clk);
    check("chain_init_iv", {state_init, init_iv}, 2'b10);
    drain("drain_chain2");
    chain = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
